multi_channel_watchdog: RTL and testbench

MULTI_CHANNEL_WATCHDOG -- requirements
Module: multi_channel_watchdog

---
 rtl/wdt_pkg.sv | 24 ++
 rtl/wdt_channel.sv | 107 ++++++++++
 rtl/multi_channel_watchdog.sv | 77 +++++++
 tb/tb_multi_channel_watchdog.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared types and parameter-derivation helpers for the multi-channel watchdog.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WARN,
    ST_TRIP
  } wdt_state_e;

  // 64-bit math: TIMEOUT_CYCLES*WARN_PCT overflows 32 bits at default settings.
  function automatic longint timeout_cycles(input longint clk_freq, input longint timeout_sec);
    return clk_freq * timeout_sec;
  endfunction

  function automatic longint warn_cycles(input longint timeout, input longint warn_pct);
    return (timeout * warn_pct) / 100;
  endfunction

  function automatic int cnt_width(input longint max_value);
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: state machine, saturating counter and seconds-remaining readout.
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int CLK_FREQ      = 125_000_000,
  parameter int TIMEOUT_SEC   = 5,
  parameter int WARN_PCT      = 80,
  parameter int WINDOW_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       heartbeat_i,
  input  logic       force_reset_i,
  input  logic       window_en_i,
  output logic       warning_o,
  output logic       triggered_o,
  output logic       early_fault_o,
  output logic [7:0] time_rem_o
);

  localparam longint TimeoutCycles = timeout_cycles(CLK_FREQ, TIMEOUT_SEC);
  localparam longint WarnCycles    = warn_cycles(TimeoutCycles, WARN_PCT);
  localparam int     CntW          = cnt_width(TimeoutCycles);

  localparam logic [CntW-1:0] TimeoutC    = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0] WarnC       = CntW'(WarnCycles);
  localparam logic [CntW:0]   WindowWideC = (CntW + 1)'(WINDOW_CYCLES);

  wdt_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            early_q, early_d;
  logic            warn_q, trig_q;
  logic [CntW:0]   cnt_plus1;
  logic            too_early;
  logic [CntW-1:0] remain;
  logic [63:0]     secs;

  // counter+1 <= WINDOW avoids a constant-false compare when the window is zero
  assign cnt_plus1 = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};
  assign too_early = window_en_i && (cnt_plus1 <= WindowWideC);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    early_d = early_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      early_d = 1'b0;
    end else if (force_reset_i) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      early_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
        ST_RUN, ST_WARN: begin
          if (heartbeat_i) begin
            if (too_early) begin
              state_d = ST_TRIP;
              early_d = 1'b1;
            end else begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end
          end else if (cnt_q == TimeoutC) begin
            state_d = ST_TRIP;
          end else begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q >= WarnC) state_d = ST_WARN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      early_q <= 1'b0;
      warn_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      early_q <= early_d;
      warn_q  <= (state_d == ST_WARN) || (state_d == ST_TRIP);
      trig_q  <= (state_d == ST_TRIP);
    end
  end

  // Division by a constant; an early trip freezes the counter so this stays meaningful.
  assign remain = TimeoutC - cnt_q;
  assign secs   = 64'(remain) / 64'(CLK_FREQ);

  assign time_rem_o    = (secs > 64'd255) ? 8'hFF : secs[7:0];
  assign warning_o     = warn_q;
  assign triggered_o   = trig_q;
  assign early_fault_o = early_q;

endmodule

// File: rtl/multi_channel_watchdog.sv
// Top level: NUM_CH independent watchdog channels plus a shared trip escalation counter.
module multi_channel_watchdog
  import wdt_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CLK_FREQ      = 125_000_000,
  parameter int TIMEOUT_SEC   = 5,
  parameter int WARN_PCT      = 80,
  parameter int WINDOW_CYCLES = 0,
  parameter int ESC_CYCLES    = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   enable,
  input  logic [NUM_CH-1:0]   heartbeat,
  input  logic [NUM_CH-1:0]   force_reset,
  input  logic                window_en,
  output logic [NUM_CH-1:0]   warning,
  output logic [NUM_CH-1:0]   triggered,
  output logic [NUM_CH-1:0]   early_fault,
  output logic [8*NUM_CH-1:0] time_remaining,
  output logic                any_triggered,
  output logic                sys_reset_req
);

  localparam int EscW = cnt_width(ESC_CYCLES);
  localparam logic [EscW-1:0] EscMaxC  = EscW'(ESC_CYCLES);
  localparam logic [EscW-1:0] EscLastC = EscW'(ESC_CYCLES - 1);

  logic [EscW-1:0] esc_q, esc_d;
  logic            sys_q, sys_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wdt_channel #(
      .CLK_FREQ     (CLK_FREQ),
      .TIMEOUT_SEC  (TIMEOUT_SEC),
      .WARN_PCT     (WARN_PCT),
      .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable[i]),
      .heartbeat_i  (heartbeat[i]),
      .force_reset_i(force_reset[i]),
      .window_en_i  (window_en),
      .warning_o    (warning[i]),
      .triggered_o  (triggered[i]),
      .early_fault_o(early_fault[i]),
      .time_rem_o   (time_remaining[8*i +: 8])
    );
  end

  assign any_triggered = |triggered;

  // Saturating at ESC_CYCLES makes the pulse one-shot until the trip clears.
  always_comb begin
    esc_d = '0;
    sys_d = 1'b0;
    if (any_triggered) begin
      esc_d = (esc_q == EscMaxC) ? esc_q : esc_q + EscW'(1);
      sys_d = (esc_q == EscLastC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esc_q <= '0;
      sys_q <= 1'b0;
    end else begin
      esc_q <= esc_d;
      sys_q <= sys_d;
    end
  end

  assign sys_reset_req = sys_q;

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a randomized run against an elapsed-time model.
module tb_multi_channel_watchdog;

  localparam int NumCh        = 2;
  localparam int ClkFreq      = 10;
  localparam int TimeoutSec   = 2;
  localparam int WarnPct      = 80;
  localparam int WindowCycles = 4;
  localparam int EscCycles    = 3;
  localparam int TCyc         = 20;
  localparam int WCyc         = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NumCh-1:0] enable = '0;
  logic [NumCh-1:0] heartbeat = '0;
  logic [NumCh-1:0] forceReset = '0;
  logic             windowEn = 1'b0;
  logic [NumCh-1:0] warning, triggered, earlyFault;
  logic [8*NumCh-1:0] timeRemaining;
  logic             anyTriggered, sysResetReq;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: elapsed cycles since the last restart, plus trip/early flags.
  bit mActive[NumCh];
  int mAge[NumCh];
  bit mTrip[NumCh];
  bit mEarly[NumCh];
  int mEsc;
  bit mPulse;

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  hb;
    logic [1:0]  fr;
    logic        win;
    logic [1:0]  expWarn;
    logic [1:0]  expTrig;
    logic [1:0]  expEarly;
    logic [15:0] expTr;
  } vec_t;

  vec_t vecTable[8];

  multi_channel_watchdog #(
    .NUM_CH       (NumCh),
    .CLK_FREQ     (ClkFreq),
    .TIMEOUT_SEC  (TimeoutSec),
    .WARN_PCT     (WarnPct),
    .WINDOW_CYCLES(WindowCycles),
    .ESC_CYCLES   (EscCycles)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .heartbeat     (heartbeat),
    .force_reset   (forceReset),
    .window_en     (windowEn),
    .warning       (warning),
    .triggered     (triggered),
    .early_fault   (earlyFault),
    .time_remaining(timeRemaining),
    .any_triggered (anyTriggered),
    .sys_reset_req (sysResetReq)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NumCh; c++) begin
      mActive[c] = 1'b0;
      mAge[c]    = 0;
      mTrip[c]   = 1'b0;
      mEarly[c]  = 1'b0;
    end
    mEsc   = 0;
    mPulse = 1'b0;
  endtask

  task automatic modelStep(input logic [NumCh-1:0] en, input logic [NumCh-1:0] hb,
                           input logic [NumCh-1:0] fr, input logic win);
    bit anyPrev;
    anyPrev = 1'b0;
    for (int c = 0; c < NumCh; c++) anyPrev |= mTrip[c];
    if (anyPrev) begin
      mPulse = (mEsc + 1 == EscCycles);
      if (mEsc < EscCycles) mEsc++;
    end else begin
      mEsc   = 0;
      mPulse = 1'b0;
    end
    for (int c = 0; c < NumCh; c++) begin
      if (!en[c]) begin
        mActive[c] = 1'b0; mAge[c] = 0; mTrip[c] = 1'b0; mEarly[c] = 1'b0;
      end else if (fr[c]) begin
        mActive[c] = 1'b1; mAge[c] = 0; mTrip[c] = 1'b0; mEarly[c] = 1'b0;
      end else if (!mActive[c]) begin
        mActive[c] = 1'b1; mAge[c] = 0;
      end else if (mTrip[c]) begin
        mTrip[c] = 1'b1;
      end else if (hb[c]) begin
        if (win && mAge[c] < WindowCycles) begin
          mTrip[c] = 1'b1; mEarly[c] = 1'b1;
        end else begin
          mAge[c] = 0;
        end
      end else if (mAge[c] == TCyc) begin
        mTrip[c] = 1'b1;
      end else begin
        mAge[c]++;
      end
    end
  endtask

  task automatic checkAgainstModel();
    logic [NumCh-1:0]   eW, eT, eE;
    logic [8*NumCh-1:0] eTr;
    int secs;
    for (int c = 0; c < NumCh; c++) begin
      eW[c] = mTrip[c] || (mActive[c] && mAge[c] > WCyc);
      eT[c] = mTrip[c];
      eE[c] = mEarly[c];
      secs = (TCyc - mAge[c]) / ClkFreq;
      eTr[8*c +: 8] = (secs > 255) ? 8'hFF : 8'(secs);
    end
    checkOutput("warning", 64'(warning), 64'(eW));
    checkOutput("triggered", 64'(triggered), 64'(eT));
    checkOutput("early_fault", 64'(earlyFault), 64'(eE));
    checkOutput("time_remaining", 64'(timeRemaining), 64'(eTr));
    checkOutput("any_triggered", 64'(anyTriggered), 64'(|eT));
    checkOutput("sys_reset_req", 64'(sysResetReq), 64'(mPulse));
  endtask

  task automatic applyStimulus(input logic [NumCh-1:0] en, input logic [NumCh-1:0] hb,
                               input logic [NumCh-1:0] fr, input logic win);
    enable = en; heartbeat = hb; forceReset = fr; windowEn = win;
    @(posedge clk);
    modelStep(en, hb, fr, win);
    #1;
    checkAgainstModel();
  endtask

  // Asserts reset between edges and checks outputs clear before any clock edge.
  task automatic doReset();
    enable = '0; heartbeat = '0; forceReset = '0; windowEn = 1'b0;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("reset_warning", 64'(warning), 64'(0));
    checkOutput("reset_triggered", 64'(triggered), 64'(0));
    checkOutput("reset_early", 64'(earlyFault), 64'(0));
    checkOutput("reset_sys", 64'(sysResetReq), 64'(0));
    checkOutput("reset_any", 64'(anyTriggered), 64'(0));
    checkOutput("reset_time_rem", 64'(timeRemaining), 64'h0202);
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic runTiming(input int edges);
    for (int k = 0; k < edges; k++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 1'b0);
      checkOutput("warn0_timing", 64'(warning[0]), 64'(k >= 17));
      checkOutput("trig0_timing", 64'(triggered[0]), 64'(k >= 21));
      checkOutput("ch1_quiet", 64'({warning[1], triggered[1], earlyFault[1]}), 64'(0));
    end
  endtask

  initial begin
    int pulses;
    int pulseEdge;
    logic [NumCh-1:0] rEn, rHb, rFr;
    logic rWin;

    vecTable[0] = '{2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0202};
    vecTable[1] = '{2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0201};
    vecTable[2] = '{2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0201};
    vecTable[3] = '{2'b01, 2'b01, 2'b00, 1'b1, 2'b01, 2'b01, 2'b01, 16'h0201};
    vecTable[4] = '{2'b01, 2'b01, 2'b00, 1'b1, 2'b01, 2'b01, 2'b01, 16'h0201};
    vecTable[5] = '{2'b01, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 16'h0202};
    vecTable[6] = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0202};
    vecTable[7] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0202};

    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecTable[i].en, vecTable[i].hb, vecTable[i].fr, vecTable[i].win);
      checkOutput("tbl_warning", 64'(warning), 64'(vecTable[i].expWarn));
      checkOutput("tbl_triggered", 64'(triggered), 64'(vecTable[i].expTrig));
      checkOutput("tbl_early", 64'(earlyFault), 64'(vecTable[i].expEarly));
      checkOutput("tbl_time_rem", 64'(timeRemaining), 64'(vecTable[i].expTr));
    end

    // Plain timeout, then escalation with heartbeat held during the trip.
    doReset();
    runTiming(22);
    pulses = 0;
    pulseEdge = -1;
    for (int k = 22; k < 30; k++) begin
      applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
      checkOutput("trip_holds", 64'(triggered[0]), 64'(1));
      if (sysResetReq) begin
        pulses++;
        pulseEdge = k;
      end
    end
    checkOutput("sys_pulse_count", 64'(pulses), 64'(1));
    checkOutput("sys_pulse_edge", 64'(pulseEdge), 64'(24));

    // Asynchronous reset mid-WARN, then identical recount.
    doReset();
    runTiming(19);
    doReset();
    runTiming(22);

    // Heartbeat at counter 19 restarts the count without tripping.
    doReset();
    for (int k = 0; k < 20; k++) applyStimulus(2'b01, 2'b00, 2'b00, 1'b0);
    checkOutput("warn_before_kick", 64'(warning[0]), 64'(1));
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
    checkOutput("kick_warning", 64'(warning[0]), 64'(0));
    checkOutput("kick_time_rem", 64'(timeRemaining[7:0]), 64'(2));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 1'b0);
      checkOutput("kick_no_trip", 64'(triggered[0]), 64'(0));
    end

    // Early trip, then enable dropped while tripped.
    doReset();
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b1);
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b1);
    checkOutput("early_trig", 64'(triggered[0]), 64'(1));
    checkOutput("early_flag", 64'(earlyFault[0]), 64'(1));
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b1);
    checkOutput("drop_flags", 64'({warning[0], triggered[0], earlyFault[0]}), 64'(0));
    checkOutput("drop_time_rem", 64'(timeRemaining[7:0]), 64'(2));

    // Randomized run, both channels independent.
    doReset();
    rWin = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) rWin = 1'($urandom_range(0, 1));
      for (int c = 0; c < NumCh; c++) begin
        rEn[c] = ($urandom_range(0, 39) != 0);
        rHb[c] = ($urandom_range(0, 23) == 0);
        rFr[c] = ($urandom_range(0, 63) == 0);
      end
      applyStimulus(rEn, rHb, rFr, rWin);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
